// File: rtl/bcd_operand_sequencer_pkg.sv
// Shared definitions for the BCD operand-entry stage and its adder-side peers.
// Holds the default digit width, the largest accepted digit, the default
// synchronizer depth and the state/phase encoding shown on the status LEDs.
package bcd_operand_sequencer_pkg;

  localparam int DIGIT_W_DEF     = 4;
  localparam int MAX_DIGIT_DEF   = 9;
  localparam int SYNC_STAGES_DEF = 2;

  // The enum values double as the phase output code.
  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_LOAD = 2'b10,
    S_SHOW = 2'b11
  } state_t;

endpackage

// File: rtl/bcd_operand_sequencer_sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous level into the clock domain and
// turns its rising edge into a registered one-cycle pulse.
// Ports:
//   clock  in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   d      in  asynchronous level input
//   pulse  out one-cycle pulse, SYNC_STAGES+1 clocks after d rises
// All synchronizer and history flops reset to RESET_VAL. With RESET_VAL=1 a
// level already high when reset releases looks like "no change", so a held
// button never produces a spurious pulse.
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist_q <= sync_q[SYNC_STAGES-1];
      // Registered so the pulse lands exactly SYNC_STAGES+1 clocks after d.
      pulse  <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

endmodule

// File: rtl/bcd_operand_sequencer.sv
// bcd_operand_sequencer: operand-entry stage in front of the BCD adder.
// The user keys digit A, then digit B (with carry-in), each confirmed by the
// enter button. Valid digits are held on a/b/c4 and load pulses once so the
// adder's result register captures the sum.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   enter  in   pushbutton level (asynchronous, pre-debounced)
//   clear  in   synchronous abort back to digit-A entry
//   din    in   digit switches
//   cin    in   carry-in switch, sampled together with digit B
//   a, b   out  operands to the adder
//   c4     out  carry-in to the adder
//   load   out  capture strobe to the adder result register
//   busy   out  high in S_B and S_LOAD
//   err    out  sticky invalid-digit flag
//   phase  out  current state code (status LEDs / debug view of the FSM)
// Handshake: load is a one-way strobe with no ready; the receiver must
// capture a/b/c4 on the single clock in which load is high. a/b/c4 are stable
// throughout that cycle and do not change until the next accepted capture,
// clear or reset.
module bcd_operand_sequencer
  import bcd_operand_sequencer_pkg::*;
#(
  parameter int DIGIT_W     = DIGIT_W_DEF,
  parameter int MAX_DIGIT   = MAX_DIGIT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enter,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] din,
  input  logic               cin,
  output logic [DIGIT_W-1:0] a,
  output logic [DIGIT_W-1:0] b,
  output logic               c4,
  output logic               load,
  output logic               busy,
  output logic               err,
  output logic [1:0]         phase
);

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

  logic   enter_p;
  state_t state, next_state;
  logic   digit_ok;
  logic   cap_a, cap_b, set_err, clr_err;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (enter),
    .pulse (enter_p)
  );

  assign digit_ok = (din <= MAX_D);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_A;
    else        state <= next_state;
  end

  // clear wins over any enter_p in the same cycle; operand clearing for it is
  // done in the register process below.
  always_comb begin
    next_state = state;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    if (clear) begin
      next_state = S_A;
    end else begin
      case (state)
        S_A: if (enter_p) begin
          if (digit_ok) begin
            cap_a      = 1'b1;
            clr_err    = 1'b1;
            next_state = S_B;
          end else begin
            set_err    = 1'b1;
          end
        end
        S_B: if (enter_p) begin
          if (digit_ok) begin
            cap_b      = 1'b1;
            clr_err    = 1'b1;
            next_state = S_LOAD;
          end else begin
            set_err    = 1'b1;
          end
        end
        S_LOAD: next_state = S_SHOW;
        S_SHOW: if (enter_p) begin
          clr_err    = 1'b1;
          next_state = S_A;
        end
        default: next_state = S_A;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a   <= '0;
      b   <= '0;
      c4  <= 1'b0;
      err <= 1'b0;
    end else if (clear) begin
      a   <= '0;
      b   <= '0;
      c4  <= 1'b0;
      err <= 1'b0;
    end else begin
      if (cap_a) a <= din;
      if (cap_b) begin
        b  <= din;
        c4 <= cin;
      end
      if (set_err)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end

  // Decoded from state so load covers exactly the S_LOAD cycle, including
  // one in which clear is also asserted.
  assign load  = (state == S_LOAD);
  assign busy  = (state == S_B) || (state == S_LOAD);
  assign phase = state;

endmodule

// File: tb/tb_bcd_operand_sequencer.sv
module tb_bcd_operand_sequencer;

  logic       clock;
  logic       reset;
  logic       enter;
  logic       clear;
  logic [3:0] din;
  logic       cin;
  logic [3:0] a, b;
  logic       c4, load, busy, err;
  logic [1:0] phase;

  int errors = 0;
  int checks = 0;

  bcd_operand_sequencer u_dut (
    .clock (clock),
    .reset (reset),
    .enter (enter),
    .clear (clear),
    .din   (din),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .c4    (c4),
    .load  (load),
    .busy  (busy),
    .err   (err),
    .phase (phase)
  );

  // ---------------- clock / reset block ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- monitors / downstream model ----------------
  int         load_cnt  = 0;
  logic       b5_seen   = 1'b0;
  logic       ep_seen   = 1'b0;
  logic       rec_phase = 1'b0;
  logic [1:0] last_phase = 2'b00;
  logic [1:0] phase_seen[$];
  logic [1:0] exp_q[$];
  logic [4:0] sum_q = 5'h00;

  // Reference BCD adder result register: {carry, digit}.
  function automatic logic [4:0] bcd_sum(input logic [3:0] x, input logic [3:0] y,
                                         input logic ci);
    int s;
    s = int'(x) + int'(y) + int'(ci);
    if (s > 9) return {1'b1, 4'(s - 10)};
    else       return {1'b0, 4'(s)};
  endfunction

  always @(negedge clock) begin
    if (load) begin
      load_cnt++;
      sum_q = bcd_sum(a, b, c4);
    end
    if (b == 4'd5) b5_seen = 1'b1;
    if (u_dut.enter_p) ep_seen = 1'b1;
    if (rec_phase && phase != last_phase) phase_seen.push_back(phase);
    last_phase = phase;
  end

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic press(input logic [3:0] d, input logic ci);
    @(negedge clock);
    din   = d;
    cin   = ci;
    enter = 1'b1;
    repeat (6) @(negedge clock);
    enter = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  cnt;
    logic found;
    reset = 1'b0;
    enter = 1'b0;
    clear = 1'b0;
    din   = 4'd0;
    cin   = 1'b0;
    repeat (3) @(negedge clock);

    // 1: reset state held for 10 cycles after release with enter low
    chk("rst_phase_in_reset", 32'(phase), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("t1_phase", 32'(phase), 32'd0);
      chk("t1_a",     32'(a),     32'd0);
      chk("t1_b",     32'(b),     32'd0);
      chk("t1_c4",    32'(c4),    32'd0);
      chk("t1_err",   32'(err),   32'd0);
      chk("t1_load",  32'(load),  32'd0);
      chk("t1_busy",  32'(busy),  32'd0);
    end

    // 2: A=4, B=7 with carry-in -> 12 on the downstream register
    rec_phase = 1'b1;
    phase_seen.delete();
    press(4'd4, 1'b0);
    chk("t2_phase_after_a", 32'(phase), 32'd1);
    chk("t2_a",             32'(a),     32'd4);
    chk("t2_busy_sb",       32'(busy),  32'd1);
    press(4'd7, 1'b1);
    rec_phase = 1'b0;
    chk("t2_phase_show", 32'(phase),    32'd3);
    chk("t2_a_held",     32'(a),        32'd4);
    chk("t2_b",          32'(b),        32'd7);
    chk("t2_c4",         32'(c4),       32'd1);
    chk("t2_load_count", 32'(load_cnt), 32'd1);
    chk("t2_sum",        32'(sum_q),    32'h12);
    chk("t2_busy_show",  32'(busy),     32'd0);
    exp_q = '{2'd1, 2'd2, 2'd3};
    chk("t2_phase_seq_len", 32'(phase_seen.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < phase_seen.size(); i++)
      chk("t2_phase_seq", 32'(phase_seen[i]), 32'(exp_q[i]));
    // S_SHOW -> S_A; din is not captured
    press(4'd8, 1'b0);
    chk("t2_back_phase", 32'(phase), 32'd0);
    chk("t2_back_a",     32'(a),     32'd4);

    // 3: invalid digit rejected, then valid one accepted
    pulse_clear();
    chk("t3_clr_a", 32'(a), 32'd0);
    press(4'd12, 1'b0);
    chk("t3_err_set", 32'(err),   32'd1);
    chk("t3_phase",   32'(phase), 32'd0);
    chk("t3_a_kept",  32'(a),     32'd0);
    press(4'd3, 1'b0);
    chk("t3_err_clr", 32'(err),   32'd0);
    chk("t3_a",       32'(a),     32'd3);
    chk("t3_phase_b", 32'(phase), 32'd1);

    // 4: clear coincident with enter_p in S_B
    cnt = load_cnt;
    @(negedge clock);
    din   = 4'd5;
    enter = 1'b1;
    repeat (3) @(negedge clock);
    chk("t4_coincide_ep", 32'(u_dut.enter_p), 32'd1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    enter = 1'b0;
    repeat (8) @(negedge clock);
    chk("t4_phase",   32'(phase),    32'd0);
    chk("t4_a",       32'(a),        32'd0);
    chk("t4_b",       32'(b),        32'd0);
    chk("t4_b5_seen", 32'(b5_seen),  32'd0);
    chk("t4_no_load", 32'(load_cnt), 32'(cnt));

    // 5: enter held across reset release -> no pulse; then latency check
    @(negedge clock);
    enter = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    ep_seen = 1'b0;
    reset   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("t5_phase_held", 32'(phase), 32'd0);
    end
    chk("t5_no_ep", 32'(ep_seen), 32'd0);
    enter = 1'b0;
    repeat (5) @(negedge clock);
    din = 4'd2;
    cin = 1'b0;
    @(negedge clock);
    enter = 1'b1;
    cnt   = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      cnt++;
      if (u_dut.enter_p) break;
    end
    chk("t5_latency", 32'(cnt), 32'd3);
    repeat (3) @(negedge clock);
    enter = 1'b0;
    repeat (6) @(negedge clock);
    chk("t5_phase_b", 32'(phase), 32'd1);
    chk("t5_a",       32'(a),     32'd2);

    // 6: asynchronous reset in the middle of the S_LOAD cycle
    @(negedge clock);
    din   = 4'd6;
    cin   = 1'b0;
    enter = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (phase == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_reached_load", 32'(found), 32'd1);
    chk("t6_load_high",    32'(load),  32'd1);
    chk("t6_a_pre",        32'(a),     32'd2);
    chk("t6_b_pre",        32'(b),     32'd6);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_load_async",  32'(load),  32'd0);
    chk("t6_a_async",     32'(a),     32'd0);
    chk("t6_b_async",     32'(b),     32'd0);
    chk("t6_phase_async", 32'(phase), 32'd0);
    enter = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t6_phase_after", 32'(phase), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
